// File: rtl/weight_buffer_pkg.sv
// Shared constants for the ping-pong weight buffer.
// Pipeline-entry field offsets sit below the lane field.
package weight_buffer_pkg;

    localparam int WB_DW     = 256;
    localparam int WB_LANE_W = 6;
    localparam int WB_RD_LAT = 1;

    localparam int PE_EN   = 0;
    localparam int PE_ALL  = 1;
    localparam int PE_TAG  = 2;
    localparam int PE_LANE = 3;

    function automatic int pe_width(input int lane_w);
        return PE_LANE + lane_w;
    endfunction

endpackage

// File: rtl/wbuf_bank.sv
// One bank of the weight buffer: NLANE words plus a valid bit each.
// Clear applies before a same-edge write so the write's valid bit survives.
module wbuf_bank
    import weight_buffer_pkg::*;
#(
    parameter int DW     = WB_DW,
    parameter int LANE_W = WB_LANE_W
) (
    input  logic              CLK,
    input  logic              RSTL,
    input  logic              CLR,
    input  logic              WE,
    input  logic              ALL,
    input  logic [LANE_W-1:0] LANE,
    input  logic [DW-1:0]     D,
    input  logic [LANE_W-1:0] RLANE,
    output logic [DW-1:0]     RDATA,
    output logic              RVALID_BIT,
    output logic              FULL
);

    localparam int NL = 2 ** LANE_W;

    logic [NL-1:0] valid_q, valid_d;
    logic [DW-1:0] data_q [NL];
    logic [DW-1:0] data_d [NL];

    // Valid bits: clear first, then set the landing lane(s).
    always_comb begin
        valid_d = valid_q;
        if (CLR) begin
            valid_d = '0;
        end
        if (WE) begin
            if (ALL) begin
                valid_d = '1;
            end else begin
                valid_d[LANE] = 1'b1;
            end
        end
    end

    // Word storage: one lane or a broadcast to every lane.
    always_comb begin
        data_d = data_q;
        for (int l = 0; l < NL; l++) begin
            if (WE && (ALL || LANE == LANE_W'(l))) begin
                data_d[l] = D;
            end
        end
    end

    // Valid state is reset; contents are qualified by it.
    always_ff @(posedge CLK or negedge RSTL) begin
        if (!RSTL) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Word array needs no reset.
    always_ff @(posedge CLK) begin
        data_q <= data_d;
    end

    assign RDATA      = data_q[RLANE];
    assign RVALID_BIT = valid_q[RLANE];
    assign FULL       = &valid_q;

endmodule

// File: rtl/weight_buffer.sv
// Ping-pong weight store between the sequencer and the MAC array.
// Issues are tagged with their target bank and land RD_LAT cycles later.
module weight_buffer
    import weight_buffer_pkg::*;
#(
    parameter int DW     = WB_DW,
    parameter int LANE_W = WB_LANE_W,
    parameter int RD_LAT = WB_RD_LAT
) (
    input  logic              CLK,
    input  logic              RSTL,
    input  logic              WBUF_PURGE,
    input  logic              WBUF_EN,
    input  logic [LANE_W-1:0] WBUF_EN_CTRL,
    input  logic              WBUF_ALL_EN,
    input  logic              WBUF_SWITCH,
    input  logic [DW-1:0]     QX,
    input  logic [LANE_W-1:0] RD_LANE,
    output logic [DW-1:0]     RD_DATA,
    output logic              RD_VALID,
    output logic              WBUF_READY,
    output logic              WBUF_FULL,
    output logic              WBUF_BANK
);

    localparam int PW = pe_width(LANE_W);

    logic [PW-1:0] pipe_q [RD_LAT];
    logic [PW-1:0] pipe_d [RD_LAT];
    logic [PW-1:0] issue;
    logic [PW-1:0] land;
    logic          wr_bank_q, wr_bank_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic [1:0]    we, clr, full, rvb;
    logic [DW-1:0] rdata [2];

    // Issue pipeline; a same-cycle switch retargets the issue to the new bank.
    always_comb begin
        issue                   = '0;
        issue[PE_EN]            = WBUF_EN;
        issue[PE_ALL]           = WBUF_ALL_EN;
        issue[PE_TAG]           = wr_bank_q ^ WBUF_SWITCH;
        issue[PE_LANE +: LANE_W] = WBUF_EN_CTRL;
        pipe_d[0] = issue;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        if (WBUF_PURGE) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_d[i] = '0;
            end
        end
    end

    // Landing steering and bank clears; purge drops the landing entry.
    always_comb begin
        land   = pipe_q[RD_LAT-1];
        we[0]  = land[PE_EN] & ~WBUF_PURGE & ~land[PE_TAG];
        we[1]  = land[PE_EN] & ~WBUF_PURGE &  land[PE_TAG];
        clr[0] = WBUF_PURGE | (WBUF_SWITCH &  wr_bank_q);
        clr[1] = WBUF_PURGE | (WBUF_SWITCH & ~wr_bank_q);
    end

    // Bank select and read-port registers, using pre-edge wr_bank.
    always_comb begin
        wr_bank_d  = wr_bank_q ^ WBUF_SWITCH;
        rd_data_d  = wr_bank_q ? rdata[0] : rdata[1];
        rd_valid_d = wr_bank_q ? rvb[0] : rvb[1];
        if (WBUF_PURGE) begin
            wr_bank_d  = 1'b0;
            rd_data_d  = '0;
            rd_valid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge CLK or negedge RSTL) begin
        if (!RSTL) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
            wr_bank_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            pipe_q     <= pipe_d;
            wr_bank_q  <= wr_bank_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    wbuf_bank #(.DW(DW), .LANE_W(LANE_W)) bank0 (
        .CLK        (CLK),
        .RSTL       (RSTL),
        .CLR        (clr[0]),
        .WE         (we[0]),
        .ALL        (land[PE_ALL]),
        .LANE       (land[PE_LANE +: LANE_W]),
        .D          (QX),
        .RLANE      (RD_LANE),
        .RDATA      (rdata[0]),
        .RVALID_BIT (rvb[0]),
        .FULL       (full[0])
    );

    wbuf_bank #(.DW(DW), .LANE_W(LANE_W)) bank1 (
        .CLK        (CLK),
        .RSTL       (RSTL),
        .CLR        (clr[1]),
        .WE         (we[1]),
        .ALL        (land[PE_ALL]),
        .LANE       (land[PE_LANE +: LANE_W]),
        .D          (QX),
        .RLANE      (RD_LANE),
        .RDATA      (rdata[1]),
        .RVALID_BIT (rvb[1]),
        .FULL       (full[1])
    );

    assign RD_DATA    = rd_data_q;
    assign RD_VALID   = rd_valid_q;
    assign WBUF_BANK  = ~wr_bank_q;
    assign WBUF_READY = wr_bank_q ? full[0] : full[1];
    assign WBUF_FULL  = wr_bank_q ? full[1] : full[0];

endmodule

// File: tb/tb_weight_buffer.sv
// Bench for weight_buffer: vector table, randomized run against an
// array/queue reference model, and directed multi-cycle sequences.
module tb_weight_buffer;

    localparam int DW     = 256;
    localparam int LANE_W = 6;
    localparam int NL     = 64;
    localparam int RD_LAT = 1;

    logic              clk = 1'b0;
    logic              rstl = 1'b0;
    logic              purge = 1'b0;
    logic              en = 1'b0;
    logic [LANE_W-1:0] en_ctrl = '0;
    logic              all_en = 1'b0;
    logic              sw = 1'b0;
    logic [DW-1:0]     qx = '0;
    logic [LANE_W-1:0] rd_lane = '0;
    logic [DW-1:0]     rd_data;
    logic              rd_valid, ready, full, bank;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    weight_buffer dut (
        .CLK          (clk),
        .RSTL         (rstl),
        .WBUF_PURGE   (purge),
        .WBUF_EN      (en),
        .WBUF_EN_CTRL (en_ctrl),
        .WBUF_ALL_EN  (all_en),
        .WBUF_SWITCH  (sw),
        .QX           (qx),
        .RD_LANE      (rd_lane),
        .RD_DATA      (rd_data),
        .RD_VALID     (rd_valid),
        .WBUF_READY   (ready),
        .WBUF_FULL    (full),
        .WBUF_BANK    (bank)
    );

    // Reference model: two banks of words/valid flags, a write-bank index
    // and a queue of outstanding issues that land RD_LAT edges later.
    typedef struct {
        bit en;
        bit all;
        int lane;
        int tag;
    } issue_t;

    logic [DW-1:0] mdata [2][NL];
    bit            mvalid [2][NL];
    int            mwr;
    issue_t        pend [$];
    logic [DW-1:0] e_rd_data;
    bit            e_rd_valid;

    function automatic bit all_valid(input int b);
        for (int l = 0; l < NL; l++) begin
            if (!mvalid[b][l]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_reset();
        for (int b = 0; b < 2; b++) begin
            for (int l = 0; l < NL; l++) mvalid[b][l] = 1'b0;
        end
        mwr = 0;
        pend.delete();
        e_rd_data = '0;
        e_rd_valid = 1'b0;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act,
                         input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_model();
        check("rd_valid", DW'(rd_valid), DW'(e_rd_valid));
        if (e_rd_valid) check("rd_data", rd_data, e_rd_data);
        check("ready", DW'(ready), DW'(all_valid(1 - mwr)));
        check("full", DW'(full), DW'(all_valid(mwr)));
        check("bank", DW'(bank), DW'(1 - mwr));
    endtask

    // One clock: drive inputs, advance the model on the edge, compare.
    task automatic cycle(input bit i_en, input bit i_all, input int i_lane,
                         input bit i_sw, input bit i_pg,
                         input logic [DW-1:0] i_qx, input int i_rl);
        issue_t p;
        int old;
        en = i_en;
        all_en = i_all;
        en_ctrl = LANE_W'(i_lane);
        sw = i_sw;
        purge = i_pg;
        qx = i_qx;
        rd_lane = LANE_W'(i_rl);
        @(posedge clk);
        if (i_pg) begin
            model_reset();
        end else begin
            old = mwr;
            e_rd_valid = mvalid[1-old][i_rl];
            e_rd_data = mdata[1-old][i_rl];
            if (i_sw) begin
                for (int l = 0; l < NL; l++) mvalid[1-old][l] = 1'b0;
                mwr = 1 - old;
            end
            if (pend.size() == RD_LAT) begin
                p = pend.pop_front();
                if (p.en) begin
                    for (int l = 0; l < NL; l++) begin
                        if (p.all || l == p.lane) begin
                            mdata[p.tag][l] = i_qx;
                            mvalid[p.tag][l] = 1'b1;
                        end
                    end
                end
            end
            p.en = i_en;
            p.all = i_all;
            p.lane = i_lane;
            p.tag = old ^ int'(i_sw);
            pend.push_back(p);
        end
        #1;
        check_model();
    endtask

    task automatic idle(input int rl);
        cycle(0, 0, 0, 0, 0, '0, rl);
    endtask

    function automatic logic [DW-1:0] rep(input logic [7:0] b);
        return {32{b}};
    endfunction

    typedef struct {
        bit en, all, sw, pg;
        int lane, rl;
        logic [7:0] qb;
        bit ready, full, bnk, rdv;
        logic [7:0] rdb;
    } vec_t;

    vec_t vt [9];
    logic [DW-1:0] rnd;
    int wait_t;

    initial begin
        model_reset();
        // en all lane sw pg rl qb | ready full bank rdv rdb
        vt[0] = '{1,1,0,0,0,0,8'h00, 0,0,1,0,8'h00};
        vt[1] = '{0,0,0,0,0,0,8'hA5, 0,1,1,0,8'h00};
        vt[2] = '{0,0,1,0,0,7,8'h00, 1,0,0,0,8'h00};
        vt[3] = '{0,0,0,0,0,7,8'h00, 1,0,0,1,8'hA5};
        vt[4] = '{1,0,1,0,3,7,8'h00, 0,0,1,1,8'hA5};
        vt[5] = '{0,0,0,0,0,3,8'h3C, 0,0,1,0,8'h00};
        vt[6] = '{0,0,1,0,0,3,8'h00, 0,0,0,0,8'h00};
        vt[7] = '{0,0,0,0,0,3,8'h00, 0,0,0,1,8'h3C};
        vt[8] = '{0,0,0,0,0,4,8'h00, 0,0,0,0,8'h00};

        // Power-on reset values.
        #3;
        check("por_bank", DW'(bank), DW'(1));
        check("por_full", DW'(full), DW'(0));
        @(negedge clk);
        rstl = 1'b1;
        @(posedge clk);
        #1;

        // Vector table: broadcast, switch, same-cycle issue and switch.
        foreach (vt[i]) begin
            cycle(vt[i].en, vt[i].all, vt[i].lane, vt[i].sw, vt[i].pg,
                  rep(vt[i].qb), vt[i].rl);
            check($sformatf("vec%0d_ready", i), DW'(ready), DW'(vt[i].ready));
            check($sformatf("vec%0d_full", i), DW'(full), DW'(vt[i].full));
            check($sformatf("vec%0d_bank", i), DW'(bank), DW'(vt[i].bnk));
            check($sformatf("vec%0d_rdv", i), DW'(rd_valid), DW'(vt[i].rdv));
            if (vt[i].rdv) begin
                check($sformatf("vec%0d_rdd", i), rd_data, rep(vt[i].rdb));
            end
        end

        // T2: fill lanes 0..63 one by one, then switch and read lane 5.
        cycle(0, 0, 0, 0, 1, '0, 0);
        for (int i = 0; i <= NL; i++) begin
            cycle(i < NL, 0, i, 0, 0, (i > 0) ? DW'((i - 1) * 'h11) : '0, 0);
            if (i == NL - 1) check("t2_not_full", DW'(full), DW'(0));
        end
        check("t2_full", DW'(full), DW'(1));
        cycle(0, 0, 0, 1, 0, '0, 5);
        check("t2_ready", DW'(ready), DW'(1));
        check("t2_bank", DW'(bank), DW'(0));
        idle(5);
        check("t2_rdd", rd_data, DW'('h55));
        check("t2_rdv", DW'(rd_valid), DW'(1));

        // T3: broadcast fills the write bank on the landing edge.
        cycle(0, 0, 0, 0, 1, '0, 0);
        cycle(1, 1, 17, 0, 0, '0, 0);
        cycle(0, 0, 0, 0, 0, rep(8'hA5), 0);
        check("t3_full", DW'(full), DW'(1));
        cycle(0, 0, 0, 1, 0, '0, 0);
        for (int l = 0; l < NL; l++) begin
            idle(l);
            check($sformatf("t3_lane%0d", l), rd_data, rep(8'hA5));
        end

        // T4: lane 63 still in flight when the switch happens.
        cycle(0, 0, 0, 0, 1, '0, 0);
        for (int i = 0; i < NL - 1; i++) begin
            cycle(1, 0, i, 0, 0, (i > 0) ? rep(8'(i - 1)) : '0, 0);
        end
        cycle(1, 0, 63, 0, 0, rep(8'd62), 0);
        check("t4_ready_lo", DW'(ready), DW'(0));
        cycle(0, 0, 0, 1, 0, rep(8'h63), 63);
        check("t4_ready_hi", DW'(ready), DW'(1));
        check("t4_full_lo", DW'(full), DW'(0));
        idle(63);
        check("t4_rdd", rd_data, rep(8'h63));

        // T6: purge while an issue is in flight.
        cycle(1, 0, 9, 0, 0, '0, 0);
        cycle(0, 0, 0, 0, 1, rep(8'h99), 0);
        check("t6_ready", DW'(ready), DW'(0));
        check("t6_full", DW'(full), DW'(0));
        check("t6_bank", DW'(bank), DW'(1));
        cycle(0, 0, 0, 1, 0, '0, 9);
        idle(9);
        check("t6_dropped", DW'(rd_valid), DW'(0));

        // T1: asynchronous reset with an issue in flight.
        cycle(1, 0, 2, 0, 0, '0, 0);
        en = 1'b0;
        #2 rstl = 1'b0;
        #1;
        check("t1_rdd", rd_data, '0);
        check("t1_rdv", DW'(rd_valid), DW'(0));
        check("t1_ready", DW'(ready), DW'(0));
        check("t1_full", DW'(full), DW'(0));
        check("t1_bank", DW'(bank), DW'(1));
        model_reset();
        #1 rstl = 1'b1;
        cycle(0, 0, 0, 0, 0, rep(8'h22), 0);
        cycle(0, 0, 0, 1, 0, '0, 2);
        idle(2);
        check("t1_no_land", DW'(rd_valid), DW'(0));

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom};
            wait_t = $urandom_range(0, 99);
            cycle($urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, NL - 1),
                  $urandom_range(0, 11) == 0,
                  wait_t == 0,
                  rnd,
                  $urandom_range(0, NL - 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
